// File: rtl/tawas_rcn_wb_queue.sv
// ---------------------------------------------------------------------------
// tawas_rcn_wb_queue
//   Writeback queue between the RCN bus interface and the shared register-file
//   write port. Load returns are buffered as {thread, reg, data} and committed
//   one per cycle whenever the pipeline leaves the write port free. RCN cannot
//   be backpressured, so a return that arrives while the queue is full and not
//   draining is dropped and reported through a sticky overflow flag.
//   A per-thread read-pending flag holds each thread off read issue until its
//   load data has been written back.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   rcn_load_*         load return: valid pulse, thread, dest reg, data
//   rd_issue*          RCN read issued this cycle and issuing thread
//   wb_port_busy       pipeline owns the write port this cycle
//   wb_en/thread/reg/data  registered writeback commit
//   rd_stall           per-thread read-outstanding flags
//   level              current entry count, 0..DEPTH
//   overflow           sticky: a load return was dropped
// ---------------------------------------------------------------------------
module tawas_rcn_wb_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rcn_load_en,
  input  logic [4:0]       rcn_load_thread,
  input  logic [2:0]       rcn_load_reg,
  input  logic [31:0]      rcn_load_data,
  input  logic             rd_issue,
  input  logic [4:0]       rd_issue_thread,
  input  logic             wb_port_busy,
  output logic             wb_en,
  output logic [4:0]       wb_thread,
  output logic [2:0]       wb_reg,
  output logic [31:0]      wb_data,
  output logic [31:0]      rd_stall,
  output logic [PTR_W:0]   level,
  output logic             overflow
);

  localparam logic [PTR_W:0] FULL_LVL = DEPTH[PTR_W:0];

  logic [39:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   level_q, level_d;
  logic             wb_en_q;
  logic [4:0]       wb_thread_q;
  logic [2:0]       wb_reg_q;
  logic [31:0]      wb_data_q;
  logic [31:0]      rd_stall_q, rd_stall_d;
  logic             overflow_q;

  logic             push, pop, full, accept, drop;
  logic [39:0]      head;
  logic [31:0]      stall_set, stall_clr;

  assign push   = rcn_load_en;
  assign pop    = (level_q != '0) && !wb_port_busy;
  assign full   = (level_q == FULL_LVL);
  // When full, a simultaneous pop frees the slot this edge, so the push fits:
  // wr_ptr == rd_ptr and the read picks up the old contents before the write.
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    case ({accept, pop})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Set wins over clear for the same thread at the same edge.
  assign stall_set  = rd_issue ? (32'd1 << rd_issue_thread) : 32'd0;
  assign stall_clr  = pop ? (32'd1 << head[39:35]) : 32'd0;
  assign rd_stall_d = (rd_stall_q & ~stall_clr) | stall_set;

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= {rcn_load_thread, rcn_load_reg, rcn_load_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      wb_en_q     <= 1'b0;
      wb_thread_q <= '0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      rd_stall_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      level_q    <= level_d;
      rd_stall_q <= rd_stall_d;
      wb_en_q    <= pop;
      if (accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
        wb_thread_q <= head[39:35];
        wb_reg_q    <= head[34:32];
        wb_data_q   <= head[31:0];
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign wb_en     = wb_en_q;
  assign wb_thread = wb_thread_q;
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;
  assign rd_stall  = rd_stall_q;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_tawas_rcn_wb_queue.sv
module tb_tawas_rcn_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rcn_load_en;
  logic [4:0]  rcn_load_thread;
  logic [2:0]  rcn_load_reg;
  logic [31:0] rcn_load_data;
  logic        rd_issue;
  logic [4:0]  rd_issue_thread;
  logic        wb_port_busy;
  logic        wb_en;
  logic [4:0]  wb_thread;
  logic [2:0]  wb_reg;
  logic [31:0] wb_data;
  logic [31:0] rd_stall;
  logic [3:0]  level;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];

  tawas_rcn_wb_queue #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .rst(rst),
    .rcn_load_en(rcn_load_en), .rcn_load_thread(rcn_load_thread),
    .rcn_load_reg(rcn_load_reg), .rcn_load_data(rcn_load_data),
    .rd_issue(rd_issue), .rd_issue_thread(rd_issue_thread),
    .wb_port_busy(wb_port_busy),
    .wb_en(wb_en), .wb_thread(wb_thread), .wb_reg(wb_reg), .wb_data(wb_data),
    .rd_stall(rd_stall), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Step past the next rising edge; inputs change and state is sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int thr, input int rg, input logic [31:0] d, input bit expect_kept);
    rcn_load_en     = 1'b1;
    rcn_load_thread = 5'(thr);
    rcn_load_reg    = 3'(rg);
    rcn_load_data   = d;
    if (expect_kept) exp_q.push_back({5'(thr), 3'(rg), d});
  endtask

  task automatic idle_load();
    rcn_load_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || level != 0) && n < 200) begin
      tick();
      n++;
    end
    chk(name, {63'd0, (exp_q.size() == 0 && level == 0)}, 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wb_en"},     {63'd0, wb_en}, 64'd0);
    chk({tag, "_wb_thread"}, {59'd0, wb_thread}, 64'd0);
    chk({tag, "_wb_reg"},    {61'd0, wb_reg}, 64'd0);
    chk({tag, "_wb_data"},   {32'd0, wb_data}, 64'd0);
    chk({tag, "_rd_stall"},  {32'd0, rd_stall}, 64'd0);
    chk({tag, "_level"},     {60'd0, level}, 64'd0);
    chk({tag, "_overflow"},  {63'd0, overflow}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    rcn_load_en = 1'b0; rcn_load_thread = '0; rcn_load_reg = '0; rcn_load_data = '0;
    rd_issue = 1'b0; rd_issue_thread = '0; wb_port_busy = 1'b0;

    // Scoreboard monitor: every commit must match the oldest expected entry.
    fork
      forever begin
        @(negedge clk);
        if (!rst && wb_en) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL commit_unexpected: got %0h expected none", {wb_thread, wb_reg, wb_data});
          end else begin
            logic [39:0] e;
            e = exp_q.pop_front();
            if ({wb_thread, wb_reg, wb_data} !== e) begin
              errors++;
              $display("FAIL commit_order: got %0h expected %0h", {wb_thread, wb_reg, wb_data}, e);
            end
          end
        end
      end
    join_none

    @(negedge clk);
    check_all_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    // T1 single load
    load(3, 5, 32'hDEADBEEF, 1'b1);
    tick(); idle_load();
    chk("t1_level_1", {60'd0, level}, 64'd1);
    chk("t1_wb_en_early", {63'd0, wb_en}, 64'd0);
    tick();
    chk("t1_wb_en", {63'd0, wb_en}, 64'd1);
    chk("t1_level_0", {60'd0, level}, 64'd0);
    tick();
    chk("t1_wb_en_off", {63'd0, wb_en}, 64'd0);
    chk("t1_wb_data_hold", {32'd0, wb_data}, 64'hDEADBEEF);

    // T2 read stall
    rd_issue = 1'b1; rd_issue_thread = 5'd7;
    tick(); rd_issue = 1'b0;
    chk("t2_stall_set", {32'd0, rd_stall}, 64'h80);
    repeat (10) tick();
    chk("t2_stall_held", {32'd0, rd_stall}, 64'h80);
    load(7, 2, 32'h0000_1234, 1'b1);
    tick(); idle_load();
    chk("t2_stall_in_queue", {32'd0, rd_stall}, 64'h80);
    tick();
    chk("t2_commit", {63'd0, wb_en}, 64'd1);
    chk("t2_stall_clr", {32'd0, rd_stall}, 64'd0);
    wait_drain("t2_drain");

    // T3 port busy
    wb_port_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      load(i, i, 32'h100 + 32'(i), 1'b1);
      tick();
    end
    idle_load();
    repeat (15) tick();
    chk("t3_level_5", {60'd0, level}, 64'd5);
    chk("t3_no_commit", {63'd0, wb_en}, 64'd0);
    wb_port_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_burst_wb_en", {63'd0, wb_en}, 64'd1);
      chk("t3_burst_level", {60'd0, level}, 64'(4 - i));
    end
    tick();
    chk("t3_burst_end", {63'd0, wb_en}, 64'd0);
    wait_drain("t3_drain");

    // T4 full: ninth load is dropped
    wb_port_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      load(8 + i, i, 32'h200 + 32'(i), 1'b1);
      tick();
    end
    chk("t4_level_8", {60'd0, level}, 64'd8);
    chk("t4_no_ovf_yet", {63'd0, overflow}, 64'd0);
    load(16, 7, 32'h2FF, 1'b0);
    tick(); idle_load();
    chk("t4_level_sat", {60'd0, level}, 64'd8);
    chk("t4_overflow", {63'd0, overflow}, 64'd1);
    wb_port_busy = 1'b0;
    wait_drain("t4_drain");
    chk("t4_ovf_sticky", {63'd0, overflow}, 64'd1);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_overflow", {63'd0, overflow}, 64'd0);
    tick();

    // T5 full with simultaneous pop: push accepted, pointers wrap
    wb_port_busy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      load(i, i, 32'h300 + 32'(i), 1'b1);
      tick();
    end
    chk("t5_level_8", {60'd0, level}, 64'd8);
    wb_port_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      load(20 + (i % 8), 7 - (i % 8), 32'h400 + 32'(i), 1'b1);
      tick();
      chk("t5_level_hold", {60'd0, level}, 64'd8);
      chk("t5_wb_en", {63'd0, wb_en}, 64'd1);
    end
    idle_load();
    chk("t5_no_ovf", {63'd0, overflow}, 64'd0);
    wait_drain("t5_drain");

    // T6 reset mid-run
    wb_port_busy = 1'b1;
    rd_issue = 1'b1; rd_issue_thread = 5'd0;
    tick();
    rd_issue_thread = 5'd4;
    tick();
    rd_issue = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load(1, i, 32'h500 + 32'(i), 1'b1);
      tick();
    end
    idle_load();
    chk("t6_level_4", {60'd0, level}, 64'd4);
    chk("t6_stall", {32'd0, rd_stall}, 64'h11);
    rst = 1'b1;
    #2;
    check_all_zero("t6_async");
    exp_q.delete();
    tick();
    rst = 1'b0;
    wb_port_busy = 1'b0;
    repeat (6) tick();
    chk("t6_idle_wb_en", {63'd0, wb_en}, 64'd0);
    chk("t6_idle_level", {60'd0, level}, 64'd0);
    load(9, 1, 32'hCAFE_F00D, 1'b1);
    tick(); idle_load();
    wait_drain("t6_new_load");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
